// File: rtl/uart_rx_fsm.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, optional parity, one-entry valid/ready holding register.
// Word is presented 2+OVERSAMPLE/2+OVERSAMPLE*(DATA_BITS+1+PARITY_EN) edges after rx falls; a full register drops new words (overrun).
module uart_rx_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 div_clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);
    localparam logic          HAS_PAR  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        RECOVER = 3'd5
    } state_e;

    state_e               state_q,      state_d;
    logic                 rx_meta_q,    rx_meta_d;
    logic                 rx_s_q,       rx_s_d;
    logic [TW-1:0]        tick_cnt_q,   tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,      shreg_d;
    logic                 par_bad_q,    par_bad_d;
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 rx_busy_q,    rx_busy_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q,    overrun_d;

    logic tick_end;
    logic stop_smp;
    logic deliver;
    logic load;

    assign tick_end = (tick_cnt_q == TICK_END);

    // State register: every flop of the block, synchronous active-low reset.
    always_ff @(posedge div_clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_bad_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_busy_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_bad_q    <= par_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_busy_q    <= rx_busy_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (tick_cnt_q == TICK_MID) state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: begin
                if (tick_end && (bit_cnt_q == LAST_BIT)) state_d = HAS_PAR ? PARITY : STOP;
            end
            PARITY: begin
                if (tick_end) state_d = STOP;
            end
            STOP: begin
                if (tick_end) state_d = rx_s_q ? IDLE : RECOVER;
            end
            RECOVER: begin
                // Hold off until the line returns high so a break cannot restart a frame.
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_comb begin
        rx_meta_d  = rx;
        rx_s_d     = rx_meta_q;
        tick_cnt_d = (state_d != state_q) ? '0 : tick_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_bad_d  = par_bad_q;

        if ((state_q == IDLE) && (state_d == START)) par_bad_d = 1'b0;
        if ((state_q == START) && (state_d == DATA)) bit_cnt_d = '0;
        if ((state_q == DATA) && tick_end) begin
            shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if ((state_q == PARITY) && tick_end) par_bad_d = (^{shreg_q, rx_s_q}) ^ PAR_ODD;

        stop_smp = (state_q == STOP) && tick_end;
        deliver  = stop_smp && rx_s_q && !par_bad_q;
        // A consumer draining the register on the same edge frees it for the new word.
        load     = deliver && (!rx_valid_q || rx_ready);

        frame_err_d  = stop_smp && !rx_s_q;
        parity_err_d = stop_smp && rx_s_q && par_bad_q;
        overrun_d    = deliver && !load;
        rx_valid_d   = load || (rx_valid_q && !rx_ready);
        rx_data_d    = load ? shreg_q : rx_data_q;
        rx_busy_d    = (state_d != IDLE);
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_busy    = rx_busy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a default instance and an even-parity instance driven with frames, checked against a frame-level model.
module tb_uart_rx_fsm;

    localparam int OS = 16;

    logic div_clk = 1'b0;
    always #5 div_clk = ~div_clk;

    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rdy0 = 1'b0, rdy1 = 1'b0;
    logic [7:0] d0, d1;
    logic       v0, v1, b0, b1, fe0, fe1, pe0, pe1, ov0, ov1;

    uart_rx_fsm #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .div_clk(div_clk), .rst_n(rst_n), .rx(rx0), .rx_ready(rdy0),
        .rx_data(d0), .rx_valid(v0), .rx_busy(b0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    uart_rx_fsm #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .div_clk(div_clk), .rst_n(rst_n), .rx(rx1), .rx_ready(rdy1),
        .rx_data(d1), .rx_valid(v1), .rx_busy(b1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    int checks = 0;
    int failures = 0;

    // Frame-level model: what each holding register should contain.
    logic       ev [2];
    logic [7:0] ed [2];

    int         cur_sel = 0;
    logic       sv, sb, sfe, spe, sov;
    logic [7:0] sd;
    assign sv  = (cur_sel != 0) ? v1  : v0;
    assign sb  = (cur_sel != 0) ? b1  : b0;
    assign sfe = (cur_sel != 0) ? fe1 : fe0;
    assign spe = (cur_sel != 0) ? pe1 : pe0;
    assign sov = (cur_sel != 0) ? ov1 : ov0;
    assign sd  = (cur_sel != 0) ? d1  : d0;

    int   m_fe, m_pe, m_ov, m_rise, m_vlow, m_busy_hi;
    logic m_prev_v;

    task automatic mon_clear();
        m_fe = 0; m_pe = 0; m_ov = 0; m_rise = -1; m_vlow = 0; m_busy_hi = 0;
        m_prev_v = sv;
    endtask

    task automatic mon(input int e);
        if (sfe) m_fe++;
        if (spe) m_pe++;
        if (sov) m_ov++;
        if (sb)  m_busy_hi++;
        if (!sv) m_vlow++;
        if (sv && !m_prev_v && m_rise < 0) m_rise = e;
        m_prev_v = sv;
    endtask

    task automatic drive(input int sel, input logic rxv, input logic rdy);
        if (sel != 0) begin rx1 = rxv; rdy1 = rdy; end
        else          begin rx0 = rxv; rdy0 = rdy; end
    endtask

    // Sends one frame starting at a negedge; edge 0 is the following posedge.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit, input logic stopv,
                              input bit rdy_pulse, input int tail_low, input int rst_at, input string name);
        logic bits [11];
        int   nb, stop_e, e, tail_drop;
        bit   aborted;
        logic prev_ev, load, exp_fe, exp_pe, exp_ov;
        cur_sel = sel;
        nb      = 10 + sel;
        stop_e  = 2 + OS / 2 + OS * (9 + sel);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        if (sel != 0) bits[9] = pbit;
        bits[nb - 1] = stopv;
        prev_ev   = ev[sel];
        aborted   = 1'b0;
        tail_drop = 0;
        #0 mon_clear();
        for (e = 0; e < nb * OS; e++) begin
            @(negedge div_clk);
            drive(sel, bits[e / OS], rdy_pulse && (e == stop_e));
            rst_n = (e != rst_at);
            @(posedge div_clk);
            #1;
            if (e == rst_at) begin
                checks++;
                if ({v0, b0, fe0, pe0, ov0, d0} !== 13'd0) begin
                    failures++;
                    $display("FAIL %s reset0: got v=%0b busy=%0b fe=%0b pe=%0b ov=%0b data=%h, want all 0",
                             name, v0, b0, fe0, pe0, ov0, d0);
                end
                checks++;
                if ({v1, b1, fe1, pe1, ov1, d1} !== 13'd0) begin
                    failures++;
                    $display("FAIL %s reset1: got v=%0b busy=%0b fe=%0b pe=%0b ov=%0b data=%h, want all 0",
                             name, v1, b1, fe1, pe1, ov1, d1);
                end
                aborted = 1'b1;
                break;
            end
            mon(e);
        end
        if (aborted) begin
            @(negedge div_clk);
            rst_n = 1'b1;
            drive(sel, 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) begin ev[k] = 1'b0; ed[k] = 8'h00; end
        end else begin
            for (int t = 0; t < tail_low; t++) begin
                @(negedge div_clk);
                drive(sel, 1'b0, 1'b0);
                @(posedge div_clk);
                #1;
                mon(e);
                if (!sb) tail_drop++;
                e++;
            end
            for (int t = 0; t < 12; t++) begin
                @(negedge div_clk);
                drive(sel, 1'b1, 1'b0);
                @(posedge div_clk);
                #1;
                mon(e);
                e++;
            end
            exp_fe = !stopv;
            exp_pe = stopv && (sel != 0) && ((^d ^ pbit) != 1'b0);
            load   = stopv && !exp_pe && (!prev_ev || rdy_pulse);
            exp_ov = stopv && !exp_pe && !load;
            if (load) begin ev[sel] = 1'b1; ed[sel] = d; end
            else if (rdy_pulse) ev[sel] = 1'b0;

            checks++;
            if (sv !== ev[sel]) begin
                failures++;
                $display("FAIL %s valid: got %0b want %0b", name, sv, ev[sel]);
            end
            if (ev[sel]) begin
                checks++;
                if (sd !== ed[sel]) begin
                    failures++;
                    $display("FAIL %s data: got %h want %h", name, sd, ed[sel]);
                end
            end
            checks++;
            if ({m_fe, m_pe, m_ov} !== {int'(exp_fe), int'(exp_pe), int'(exp_ov)}) begin
                failures++;
                $display("FAIL %s flags: got fe=%0d pe=%0d ov=%0d cycles, want fe=%0d pe=%0d ov=%0d",
                         name, m_fe, m_pe, m_ov, exp_fe, exp_pe, exp_ov);
            end
            if (load && !prev_ev) begin
                checks++;
                if (m_rise !== stop_e) begin
                    failures++;
                    $display("FAIL %s latency: valid rose at edge %0d want %0d", name, m_rise, stop_e);
                end
            end
            if (prev_ev && !(rdy_pulse && !load)) begin
                checks++;
                if (m_vlow !== 0) begin
                    failures++;
                    $display("FAIL %s hold: valid low for %0d cycles want 0", name, m_vlow);
                end
            end
            if (tail_low > 0) begin
                checks++;
                if (tail_drop !== 0) begin
                    failures++;
                    $display("FAIL %s recover: busy low %0d cycles while line low, want 0", name, tail_drop);
                end
            end
            checks++;
            if (sb !== 1'b0) begin
                failures++;
                $display("FAIL %s idle: busy got %0b want 0", name, sb);
            end
        end
    endtask

    task automatic consume(input int sel, input string name);
        cur_sel = sel;
        @(negedge div_clk);
        drive(sel, 1'b1, 1'b1);
        @(posedge div_clk);
        #1;
        checks++;
        if (sv !== 1'b0) begin
            failures++;
            $display("FAIL %s consume: valid got %0b want 0", name, sv);
        end
        @(negedge div_clk);
        drive(sel, 1'b1, 1'b0);
        ev[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge div_clk);
        #1;
        checks++;
        if ({v0, b0, fe0, pe0, ov0, d0, v1, b1, fe1, pe1, ov1, d1} !== 26'd0) begin
            failures++;
            $display("FAIL reset: got v0=%0b b0=%0b d0=%h v1=%0b b1=%0b d1=%h errs=%0b%0b%0b%0b%0b%0b, want all 0",
                     v0, b0, d0, v1, b1, d1, fe0, pe0, ov0, fe1, pe1, ov1);
        end
        @(negedge div_clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin ev[k] = 1'b0; ed[k] = 8'h00; end
        repeat (5) @(negedge div_clk);
    endtask

    task automatic test_basic();
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 0, -1, "basic_a5");
    endtask

    task automatic test_glitch();
        consume(0, "glitch_pre");
        cur_sel = 0;
        #0 mon_clear();
        for (int e = 0; e < 40; e++) begin
            @(negedge div_clk);
            rx0 = (e < 3) ? 1'b0 : 1'b1;
            @(posedge div_clk);
            #1;
            mon(e);
        end
        checks++;
        if (!(m_busy_hi > 0 && m_busy_hi < 10)) begin
            failures++;
            $display("FAIL glitch busy: high %0d cycles, want 1..9", m_busy_hi);
        end
        checks++;
        if ({sv, m_fe != 0, m_pe != 0, m_ov != 0} !== 4'b0000) begin
            failures++;
            $display("FAIL glitch quiet: valid=%0b fe=%0d pe=%0d ov=%0d, want all 0", sv, m_fe, m_pe, m_ov);
        end
    endtask

    task automatic test_frame_err();
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 40, -1, "frame_err_3c");
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic       p;
        send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0, 0, -1, "parity_bad_07");
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0, 0, -1, "parity_ok_07");
        for (int i = 0; i < 4; i++) begin
            consume(1, "parity_rand_pre");
            d = 8'($urandom);
            p = 1'($urandom);
            send_frame(1, d, p, 1'b1, 1'b0, 0, -1, "parity_rand");
        end
    endtask

    task automatic test_overrun();
        consume(0, "overrun_pre");
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 0, -1, "ovr_first_11");
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0, 0, -1, "ovr_drop_22");
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 0, -1, "ovr_ready_22");
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       s;
        bit         r;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            r = 1'($urandom);
            send_frame(0, d, 1'b0, s, r, 0, -1, "rand");
        end
    endtask

    task automatic test_reset_mid();
        if (!ev[0]) send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b0, 0, -1, "reset_preload");
        send_frame(0, 8'($urandom), 1'b0, 1'b1, 1'b0, 0, 88, "reset_mid");
        repeat (20) @(negedge div_clk);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 0, -1, "after_reset_5a");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_parity();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
